// File: rtl/octa16_pkg.sv
// Shared Octa16 definitions: instruction width, opcode classes, NOP encoding
// and the fetch-stage state type.
package octa16_pkg;

    localparam int INST_W       = 16;
    localparam int PC_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        OP_R = 3'b000,
        OP_I = 3'b001,
        OP_L = 3'b010,
        OP_S = 3'b011,
        OP_B = 3'b100,
        OP_J = 3'b101,
        OP_U = 3'b110
    } opcode_t;

    // I-type with all-zero fields: adds zero into x0
    localparam logic [INST_W-1:0] NOP = {OP_I, 13'h0000};

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN
    } fetch_state_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/octa16_fetch_fifo.sv
// Show-ahead in-order queue with synchronous flush; head is valid whenever
// count is non-zero.
module octa16_fetch_fifo
    import octa16_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // Storage is cleared on reset so the head (and thus the decoder view) reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/octa16_fetch.sv
// Octa16 instruction fetch: sequential PC generation, bounded outstanding
// reads, in-order buffering toward decode and redirect handling.
module octa16_fetch
    import octa16_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   inst_pc
);

    localparam int CNT_W = cnt_width(DEPTH);

    fetch_state_t state, state_nxt;

    logic [PC_W-1:0]        fetch_pc, fetch_pc_nxt;
    logic [PC_W-1:0]        resp_pc, resp_pc_nxt;
    logic [CNT_W-1:0]       outstanding, outstanding_nxt;
    logic [CNT_W-1:0]       drop_cnt, drop_cnt_nxt;
    logic [CNT_W-1:0]       count;
    logic [CNT_W:0]         occ;
    logic [PC_W-1:0]        redirect_tgt;
    logic                   redirect_take;
    logic                   req_hs;
    logic                   rsp_dec;
    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic [PC_W+INST_W-1:0] head;

    assign redirect_tgt  = redirect_pc & ~PC_W'(1);
    assign redirect_take = redirect_valid && (state != BOOT);
    assign pop           = inst_valid && inst_ready;
    assign req_hs        = imem_req_valid && imem_req_ready;
    assign rsp_dec       = imem_rsp_valid && (outstanding != '0);
    assign push          = imem_rsp_valid && (drop_cnt == '0) && !redirect_take;

    // Occupancy counts the word leaving this cycle as already gone, so a 1-cycle
    // memory with a free-running decoder sustains one word per cycle. It can only
    // fall without a request handshake, so a raised request stays raised.
    assign occ = {1'b0, outstanding} + {1'b0, count} - {{CNT_W{1'b0}}, pop};

    assign imem_req_valid = (state == RUN) && !redirect_valid && (occ < (CNT_W+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign inst_valid = !fifo_empty;
    assign inst_out   = head[INST_W-1:0];
    assign inst_pc    = head[PC_W+INST_W-1:INST_W];

    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        resp_pc_nxt     = resp_pc;
        drop_cnt_nxt    = drop_cnt;
        outstanding_nxt = outstanding + CNT_W'(req_hs) - CNT_W'(rsp_dec);

        if (req_hs) begin
            fetch_pc_nxt = fetch_pc + PC_W'(2);
        end
        if (push) begin
            resp_pc_nxt = resp_pc + PC_W'(2);
        end
        if (imem_rsp_valid && (drop_cnt != '0)) begin
            drop_cnt_nxt = drop_cnt - CNT_W'(1);
        end

        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            DRAIN:   if (drop_cnt_nxt == '0) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase

        // Everything still in flight after this cycle belongs to the old stream.
        if (redirect_take) begin
            fetch_pc_nxt = redirect_tgt;
            resp_pc_nxt  = redirect_tgt;
            drop_cnt_nxt = outstanding_nxt;
            state_nxt    = (outstanding_nxt != '0) ? DRAIN : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            resp_pc     <= resp_pc_nxt;
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_cnt_nxt;
        end
    end

    octa16_fetch_fifo #(
        .WIDTH (PC_W + INST_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_take),
        .push      (push),
        .push_data ({resp_pc, imem_rsp_data}),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (count)
    );

endmodule

// File: tb/tb_octa16_fetch.sv
// Randomized scoreboard bench for octa16_fetch: an in-order memory model plus an
// epoch-based model of which words decode must see.
module tb_octa16_fetch;

    localparam int              DEPTH    = 2;
    localparam logic [15:0]     RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [15:0] imem_rsp_data = 16'h0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [15:0] inst_out;
    logic [15:0] inst_pc;

    typedef struct { logic [15:0] addr; int due; int epoch; } mreq_t;
    typedef struct { logic [15:0] pc; logic [15:0] inst; } exp_t;

    mreq_t       memq[$];
    exp_t        sb[$];
    int          cyc = 0;
    int          epoch = 0;
    logic [15:0] exp_req_addr = RESET_PC;
    int          mem_lat = 1;
    logic        rand_req = 1'b0;
    logic        rand_inst = 1'b0;
    logic        req_ready_fix = 1'b1;
    logic        inst_ready_fix = 1'b1;
    int          n_cmp = 0;
    int          n_fail = 0;

    octa16_fetch #(.PC_W(16), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeoutFail(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // One cycle of stimulus, driven 1 time unit after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 16'hA000 | memq[0].addr;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 16'($urandom);
        end
        imem_req_ready = rand_req  ? ($urandom_range(0, 3) != 0) : req_ready_fix;
        inst_ready     = rand_inst ? ($urandom_range(0, 3) != 0) : inst_ready_fix;
        redirect_valid = 1'b0;
    endtask

    task automatic waitReq(input string name, input logic [15:0] addr);
        for (int i = 0; i < 100; i++) begin
            applyStimulus();
            #1;
            if (imem_req_valid && imem_req_ready) begin
                checkOutput(name, imem_req_addr, addr);
                return;
            end
        end
        timeoutFail(name);
    endtask

    task automatic waitInst(input string name, input logic [15:0] pc);
        for (int i = 0; i < 100; i++) begin
            applyStimulus();
            #1;
            if (inst_valid) begin
                checkOutput(name, inst_pc, pc);
                return;
            end
        end
        timeoutFail(name);
    endtask

    task automatic waitOutstanding2(input string name);
        for (int i = 0; i < 100; i++) begin
            applyStimulus();
            #1;
            if (memq.size() == 2) return;
        end
        timeoutFail(name);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_valid"}, imem_req_valid, 0);
        checkOutput({tag, "_req_addr"}, imem_req_addr, RESET_PC);
        checkOutput({tag, "_inst_valid"}, inst_valid, 0);
        checkOutput({tag, "_inst_out"}, inst_out, 0);
        checkOutput({tag, "_inst_pc"}, inst_pc, 0);
    endtask

    // Reference model: memory, request-address sequence and expected delivery stream.
    // A word is owed to decode only if its request was issued after the latest redirect.
    initial begin
        mreq_t r;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                memq.delete();
                sb.delete();
                exp_req_addr = RESET_PC;
            end else begin
                if (imem_rsp_valid) begin
                    r = memq.pop_front();
                    if (r.epoch == epoch && !redirect_valid)
                        sb.push_back('{pc: r.addr, inst: 16'hA000 | r.addr});
                end
                if (imem_req_valid && imem_req_ready) begin
                    checkOutput("req_addr", imem_req_addr, exp_req_addr);
                    if (redirect_valid) timeoutFail("req_during_redirect");
                    memq.push_back('{addr: imem_req_addr,
                                     due: cyc + ((mem_lat == 0) ? $urandom_range(1, 4) : mem_lat),
                                     epoch: epoch});
                    exp_req_addr = exp_req_addr + 16'd2;
                end
                if (redirect_valid) begin
                    epoch++;
                    exp_req_addr = redirect_pc & 16'hFFFE;
                    sb.delete();
                end
            end
        end
    end

    // Monitor: every handoff to decode is popped from the scoreboard and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_inst: got pc %h inst %h, required no delivery", inst_pc, inst_out);
                end else begin
                    e = sb.pop_front();
                    checkOutput("inst_pc", inst_pc, e.pc);
                    checkOutput("inst_out", inst_out, e.inst);
                end
            end
        end
    end

    initial begin
        int c0, c1, pops, pop_pc;
        c0 = 0;
        c1 = 0;

        repeat (3) applyStimulus();
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;

        $display("[TB] test 1: sequential fetch, latency and throughput");
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            #1;
            if (imem_req_valid && imem_req_ready) begin c0 = cyc; break; end
        end
        checkOutput("first_req_addr", imem_req_addr, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            #1;
            if (inst_valid) begin c1 = cyc; break; end
        end
        checkOutput("first_latency", c1 - c0, 2);
        checkOutput("first_inst_pc", inst_pc, 16'h0000);
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            #1;
            if (inst_valid && inst_ready) pops++;
        end
        checkOutput("throughput", pops, 20);

        $display("[TB] test 2: decoder backpressure");
        inst_ready_fix = 1'b0;
        repeat (10) applyStimulus();
        #1;
        checkOutput("bp_req_valid", imem_req_valid, 0);
        checkOutput("bp_inst_valid", inst_valid, 1);
        checkOutput("bp_buffered", sb.size(), DEPTH);
        checkOutput("bp_outstanding", memq.size(), 0);
        inst_ready_fix = 1'b1;
        repeat (20) applyStimulus();

        $display("[TB] test 3: redirect with two requests outstanding");
        mem_lat = 3;
        waitOutstanding2("redir_wait");
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0041;
        applyStimulus();
        #1;
        checkOutput("redir_flush", inst_valid, 0);
        waitReq("redir_req_addr", 16'h0040);
        waitInst("redir_first_pc", 16'h0040);
        repeat (15) applyStimulus();

        $display("[TB] test 4: back-to-back redirects");
        waitOutstanding2("redir2_wait");
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        applyStimulus();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        waitReq("redir2_req_addr", 16'h0200);
        waitInst("redir2_first_pc", 16'h0200);
        repeat (15) applyStimulus();

        $display("[TB] test 5: redirect with coincident response and pop");
        mem_lat = 1;
        pop_pc  = -1;
        for (int i = 0; i < 50; i++) begin
            applyStimulus();
            #1;
            if (imem_rsp_valid && inst_valid && inst_ready) begin
                pop_pc         = int'(inst_pc);
                redirect_valid = 1'b1;
                redirect_pc    = 16'h0300;
                break;
            end
        end
        if (pop_pc < 0) timeoutFail("coinc_wait");
        applyStimulus();
        #1;
        checkOutput("coinc_flush", inst_valid, 0);
        waitInst("coinc_first_pc", 16'h0300);
        repeat (10) applyStimulus();

        $display("[TB] random phase");
        mem_lat   = 0;
        rand_req  = 1'b1;
        rand_inst = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            applyStimulus();
            if ($urandom_range(0, 24) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 16'($urandom);
            end
        end
        rand_req  = 1'b0;
        rand_inst = 1'b0;
        mem_lat   = 1;
        repeat (10) applyStimulus();

        $display("[TB] test 6: PC wrap and mid-stream reset");
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFA;
        waitReq("wrap_a", 16'hFFFA);
        waitReq("wrap_b", 16'hFFFC);
        waitReq("wrap_c", 16'hFFFE);
        waitReq("wrap_d", 16'h0000);
        repeat (3) applyStimulus();
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        repeat (3) applyStimulus();
        rst_n = 1'b1;
        waitReq("post_reset_addr", RESET_PC);
        repeat (10) applyStimulus();
        pops = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            #1;
            if (inst_valid && inst_ready) pops++;
        end
        checkOutput("post_reset_throughput", pops, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
